// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan scheduler.
// Latency: none; declarations only.
// Backpressure: not applicable.
package adc_pkg;
    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int RES_W  = 12;

    typedef logic [CH_W-1:0]  chan_t;
    typedef logic [RES_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SCAN
    } sched_state_t;
endpackage

// File: rtl/adc_next_chan.sv
// Finds the next enabled channel strictly above cur, wrapping; cur itself is the last candidate.
// Latency: combinational.
// Backpressure: not applicable.
module adc_next_chan
    import adc_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  chan_t             cur,
    output chan_t             nxt,
    output logic              none_set
);

    // Walk candidates from farthest to nearest so the nearest set bit is the final assignment.
    always_comb begin
        nxt      = cur;
        none_set = (mask == '0);
        for (int i = NUM_CH; i >= 1; i--) begin
            if (mask[cur + chan_t'(i)]) begin
                nxt = cur + chan_t'(i);
            end
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC channel sequencer with one-frame result tagging and per-channel averaging.
// Latency: res_valid one cycle after the frame_done that completes 2^AVG_LOG2 samples.
// Backpressure: none; at most one result per frame, bank and fresh flags readable any time.
module adc_scan_scheduler #(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 2,
    parameter int RES_W    = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              frame_done,
    input  logic [RES_W-1:0]  adc_result,
    output logic [2:0]        chan_sel,
    output logic              res_valid,
    output logic [2:0]        res_ch,
    output logic [RES_W-1:0]  res_data,
    input  logic [2:0]        rd_ch,
    output logic [RES_W-1:0]  rd_data,
    input  logic              rd_ack,
    output logic [NUM_CH-1:0] fresh,
    output logic              busy
);
    import adc_pkg::*;

    localparam int NAVG  = 1 << AVG_LOG2;
    localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = RES_W + AVG_LOG2;
    localparam logic [CW-1:0] LAST = CW'(NAVG - 1);

    sched_state_t      state, state_nxt;
    chan_t             cfg_prev, scan_cur, nxt_ch;
    logic              none_set, start, stop, run, sample, wr_en;
    logic [CW-1:0]     vis_cnt, acc_cnt;
    logic [ACC_W-1:0]  acc, acc_total;
    logic [RES_W-1:0]  avg;
    logic [RES_W-1:0]  bank [NUM_CH];
    logic [NUM_CH-1:0] wr_mask, ack_mask;

    // From IDLE, searching above channel 7 yields the lowest enabled channel.
    assign scan_cur = (state == IDLE) ? chan_t'(NUM_CH - 1) : chan_t'(chan_sel);

    adc_next_chan u_next (
        .mask     (ch_mask),
        .cur      (scan_cur),
        .nxt      (nxt_ch),
        .none_set (none_set)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: all transitions happen on frame_done only.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        if (frame_done) begin
            unique case (state)
                IDLE: begin
                    if (enable && !none_set) begin
                        state_nxt = PRIME;
                        start     = 1'b1;
                    end
                end
                PRIME, SCAN: begin
                    if (!enable || none_set) begin
                        state_nxt = IDLE;
                        stop      = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The frame ending in PRIME carries a result for no scheduled channel, so only SCAN samples.
    assign run       = frame_done && (state != IDLE) && !stop;
    assign sample    = run && (state == SCAN);
    assign acc_total = acc + ACC_W'(adc_result);
    assign avg       = RES_W'(acc_total >> AVG_LOG2);
    assign wr_en     = sample && (acc_cnt == LAST);
    assign wr_mask   = wr_en  ? (NUM_CH'(1) << cfg_prev) : '0;
    assign ack_mask  = rd_ack ? (NUM_CH'(1) << rd_ch)    : '0;
    assign rd_data   = bank[rd_ch];
    assign busy      = (state != IDLE);

    // Channel sequencing, pipeline tag and accumulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_sel  <= '0;
            cfg_prev  <= '0;
            vis_cnt   <= '0;
            acc       <= '0;
            acc_cnt   <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= 1'b0;
            if (start || stop) begin
                acc     <= '0;
                acc_cnt <= '0;
                if (start) begin
                    chan_sel <= nxt_ch;
                    vis_cnt  <= '0;
                end
            end else if (run) begin
                cfg_prev <= chan_t'(chan_sel);
                if (vis_cnt == LAST) begin
                    chan_sel <= nxt_ch;
                    vis_cnt  <= '0;
                end else begin
                    vis_cnt <= vis_cnt + CW'(1);
                end
                if (sample) begin
                    if (wr_en) begin
                        res_valid <= 1'b1;
                        res_ch    <= cfg_prev;
                        res_data  <= avg;
                        acc       <= '0;
                        acc_cnt   <= '0;
                    end else begin
                        acc     <= acc_total;
                        acc_cnt <= acc_cnt + CW'(1);
                    end
                end
            end
        end
    end

    // Result bank and fresh flags; a write beats a simultaneous rd_ack to the same channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
            fresh <= '0;
        end else begin
            if (wr_en) bank[cfg_prev] <= avg;
            fresh <= (fresh & ~ack_mask) | wr_mask;
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized scoreboard bench for adc_scan_scheduler with a frame-level reference model.
// Latency: expected results queued at the completing frame edge, popped on res_valid.
// Backpressure: none; the monitor samples on every falling edge.
module tb_adc_scan_scheduler;
    localparam int AVG  = 2;
    localparam int NAVG = 1 << AVG;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] dat;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic        frame_done = 1'b0;
    logic [11:0] adc_result = '0;
    logic [2:0]  chan_sel;
    logic        res_valid;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic [2:0]  rd_ch = '0;
    logic [11:0] rd_data;
    logic        rd_ack = 1'b0;
    logic [7:0]  fresh;
    logic        busy;

    int total = 0;
    int bad   = 0;

    adc_scan_scheduler #(.NUM_CH(8), .AVG_LOG2(AVG), .RES_W(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .ch_mask    (ch_mask),
        .frame_done (frame_done),
        .adc_result (adc_result),
        .chan_sel   (chan_sel),
        .res_valid  (res_valid),
        .res_ch     (res_ch),
        .res_data   (res_data),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .rd_ack     (rd_ack),
        .fresh      (fresh),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_cur: channel configured for the frame in progress (-1 when idle).
    // m_last: channel configured for the previous frame, i.e. owner of the result now arriving.
    int          m_cur, m_last, m_visit, m_sum;
    int          m_samp[$];
    logic [2:0]  m_chan;
    logic [11:0] m_bank [8];
    logic [7:0]  m_fresh, m_clr, m_set;
    res_t        exp_q[$];

    function automatic int next_en(input logic [7:0] m, input int cur);
        for (int i = 1; i <= 8; i++) if (m[(cur + i) % 8]) return (cur + i) % 8;
        return cur;
    endfunction

    task automatic model_reset();
        m_cur = -1; m_last = -1; m_visit = 0; m_chan = '0; m_fresh = '0;
        m_samp.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) m_bank[i] = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                m_clr = '0; m_set = '0;
                if (rd_ack) m_clr[rd_ch] = 1'b1;
                if (frame_done) begin
                    if (m_cur < 0) begin
                        if (enable && ch_mask != 0) begin
                            m_cur = next_en(ch_mask, 7); m_chan = m_cur[2:0];
                            m_visit = 0; m_last = -1; m_samp.delete();
                        end
                    end else if (!enable || ch_mask == 0) begin
                        m_cur = -1;
                    end else begin
                        if (m_last >= 0) begin
                            m_samp.push_back(int'(adc_result));
                            if (m_samp.size() == NAVG) begin
                                m_sum = 0;
                                foreach (m_samp[k]) m_sum += m_samp[k];
                                exp_q.push_back('{ch: m_last[2:0], dat: 12'(m_sum / NAVG)});
                                m_bank[m_last] = 12'(m_sum / NAVG);
                                m_set[m_last] = 1'b1;
                                m_samp.delete();
                            end
                        end
                        m_last = m_cur;
                        m_visit++;
                        if (m_visit == NAVG) begin
                            m_cur = next_en(ch_mask, m_cur); m_chan = m_cur[2:0]; m_visit = 0;
                        end
                    end
                end
                m_fresh = (m_fresh & ~m_clr) | m_set;
            end
        end
    end

    // ---------------- monitor ----------------
    res_t got;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (res_valid) begin
                    check("res_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        got = exp_q.pop_front();
                        check("res_ch", res_ch, got.ch);
                        check("res_data", res_data, got.dat);
                    end
                end
                check("chan_sel", chan_sel, m_chan);
                check("busy", busy, int'(m_cur >= 0));
                check("fresh", fresh, m_fresh);
                check("rd_data", rd_data, m_bank[rd_ch]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_cyc();
        tick();
        frame_done = 1'b0;
        rd_ch  = 3'($urandom_range(0, 7));
        rd_ack = ($urandom_range(0, 7) == 0);
    endtask

    task automatic frame(input logic [11:0] val, input int gap, input bit ack, input logic [2:0] ach);
        repeat (gap) idle_cyc();
        tick();
        frame_done = 1'b1;
        adc_result = val;
        if (ack) begin
            rd_ack = 1'b1; rd_ch = ach;
        end else begin
            rd_ch  = 3'($urandom_range(0, 7));
            rd_ack = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic rframe(input logic [11:0] val);
        frame(val, $urandom_range(1, 4), 1'b0, 3'd0);
    endtask

    task automatic quiet_cyc(input logic [2:0] ch);
        tick(); frame_done = 1'b0; rd_ack = 1'b0; rd_ch = ch; #1;
    endtask

    initial begin
        int r;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int r;
        repeat (3) tick();
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_chan_sel", chan_sel, 0);
        check("rst_fresh", fresh, 0);
        check("rst_busy", busy, 0);
        tick(); reset_n = 1'b1;
        repeat (2) idle_cyc();

        // Averaging on a single channel; rd_ack collides with the bank write.
        enable = 1'b1; ch_mask = 8'h08;
        rframe(12'h555);
        rframe(12'hAAA);
        rframe(12'hFFF); rframe(12'hFFF); rframe(12'hFFF);
        frame(12'hFFC, 2, 1'b1, 3'd3);
        quiet_cyc(3'd3);
        check("avg_bank3", rd_data, 12'hFFE);
        check("avg_fresh3", int'(fresh[3]), 1);

        // Disable, then mask change in the middle of a visit.
        enable = 1'b0;
        rframe(12'h111);
        quiet_cyc(3'd0);
        check("disable_busy", busy, 0);
        enable = 1'b1; ch_mask = 8'h03;
        rframe(12'h010); rframe(12'h020); rframe(12'h030);
        idle_cyc();
        ch_mask = 8'h80;
        rframe(12'h040); rframe(12'h050);
        quiet_cyc(3'd0);
        check("mask_adv_chan", chan_sel, 7);
        rframe(12'h060); rframe(12'h070); rframe(12'h080); rframe(12'h090);

        // Disable: no further results.
        enable = 1'b0;
        rframe(12'h0AA);
        quiet_cyc(3'd0);
        check("disable2_busy", busy, 0);
        repeat (3) rframe(12'h0BB);

        // Reset in the middle of a scan.
        enable = 1'b1; ch_mask = 8'hA4;
        repeat (9) rframe(12'($urandom));
        tick(); frame_done = 1'b0; #2;
        reset_n = 1'b0; #1;
        check("midrst_chan_sel", chan_sel, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fresh", fresh, 0);
        check("midrst_res_data", res_data, 0);
        check("midrst_res_valid", res_valid, 0);
        tick(); tick(); #2;
        reset_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       ch_mask = 8'($urandom_range(1, 255));
            else if (r < 7)  ch_mask = '0;
            else if (r < 9)  enable = ~enable;
            else if (r < 20) enable = 1'b1;
            if (ch_mask == 0 && r > 60) ch_mask = 8'($urandom_range(1, 255));
            rframe(12'($urandom));
        end

        repeat (4) idle_cyc();
        #4;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Sequences the 8-channel serial ADC front end: picks the channel code for every conversion frame and steps round-robin through the enabled channels.
- Compensates for the converter's one-frame pipeline: the result read in frame k belongs to the channel configured in frame k-1.
- Averages 2^AVG_LOG2 conversions per channel, stores the latest average per channel in a register bank, and emits a result strobe.
- Sits between the ADC serial interface (drives its chan input, consumes its result) and the application logic.

Parameters:
- NUM_CH, 8, number of ADC channels (channel code width CH_W = 3).
- AVG_LOG2, 2, log2 of the samples averaged per channel visit (0 means no averaging).
- RES_W, 12, ADC result width.

Ports:
- clk  in  1  system clock, the same clock as the ADC frame counter.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable.
- ch_mask  in  NUM_CH  channel enable bits, bit i = channel i.
- frame_done  in  1  one-cycle pulse at the end of each ADC frame; adc_result is valid in the same cycle.
- adc_result  in  RES_W  conversion result from the ADC interface.
- chan_sel  out  3  channel code sent to the ADC interface.
- res_valid  out  1  one-cycle pulse when an averaged result completes.
- res_ch  out  3  channel of res_data.
- res_data  out  RES_W  averaged result.
- rd_ch  in  3  register-bank read address.
- rd_data  out  RES_W  bank[rd_ch], combinational read.
- rd_ack  in  1  clears fresh[rd_ch].
- fresh  out  NUM_CH  per-channel "new value since last rd_ack" flags.
- busy  out  1  high in the PRIME and SCAN states.

Behaviour:
- Reset values:
  - chan_sel=0, res_valid=0, res_ch=0, res_data=0, bank all 0, fresh=0, busy=0.
  - Internal state: state=IDLE, acc=0, cnt=0, cfg_prev=0.
- All state changes occur only on a frame_done cycle, except rd_ack handling and the reset itself.
- State IDLE:
  - Condition: enable=1 and ch_mask!=0 at frame_done.
  - Action: chan_sel <= lowest set bit of ch_mask; cfg_cnt=0; go to PRIME.
- State PRIME (one frame):
  - At frame_done, discard adc_result, because it belongs to no scheduled channel.
  - Load cfg_prev <= chan_sel and go to SCAN.
- State SCAN, at every frame_done:
  - Tag the result with cfg_prev.
  - Load cfg_prev <= chan_sel.
  - acc += adc_result; acc width is RES_W+AVG_LOG2 and cannot overflow.
  - When acc_cnt reaches 2^AVG_LOG2 - 1:
    - res_data = acc_total >> AVG_LOG2 (truncating).
    - Pulse res_valid for 1 cycle, the cycle after frame_done, with res_ch = tag.
    - Write bank[tag] and set fresh[tag].
    - Clear acc and acc_cnt.
  - Channel advance: after chan_sel has been configured for 2^AVG_LOG2 frames, chan_sel <= next set bit of ch_mask above chan_sel, wrapping 7 -> 0. If it is the only set bit, chan_sel holds.
  - ch_mask is sampled only at advance time. A mask change mid-visit takes effect at the next advance.
- Leaving SCAN:
  - Condition: enable=0 or ch_mask=0 at a frame_done.
  - Action: go to IDLE at that frame_done; discard the partial accumulation; chan_sel is unchanged.
- Latency: the first res_valid occurs 2^AVG_LOG2 + 1 frames after leaving IDLE.
- Simultaneous events:
  - Bank write and rd_ack to the same channel in the same cycle: the set wins, and fresh stays 1.
  - rd_data shows the old value until the cycle after the write.
- reset_n asserted mid-frame: everything returns to reset values immediately; the next frame restarts via IDLE/PRIME.
- frame_done while reset is active is ignored.

Decomposition:
- Package adc_pkg:
  - Constants NUM_CH, CH_W=3, RES_W=12.
  - Typedef chan_t (logic [2:0]).
  - Typedef sample_t (logic [11:0]).
  - Enum sched_state_t {IDLE, PRIME, SCAN}.
- Sub-module adc_next_chan (combinational):
  - Inputs: mask, current channel.
  - Outputs: next enabled channel with wrap, and none_set.
  - Reused for the IDLE start (current = 7, giving the lowest set bit).

Test Plan:
- Prime discard: AVG_LOG2=0, mask=8'b0000_0001, enable=1, results 0xAAA then 0x123. Response: first frame discarded; res_valid with ch=0, data=0x123.
- Round-robin and pipeline tagging: AVG_LOG2=0, mask=8'b1010_0100, frames return 0x100, 0x200, 0x300, 0x400. Response: chan_sel sequence 2,5,7,2; results tagged ch 2,5,7 with 0x200, 0x300, 0x400.
- Averaging: AVG_LOG2=2, mask=8'b0000_1000, samples 0xFFF,0xFFF,0xFFF,0xFFC after prime. Response: one res_valid, ch=3, data=0xFFE; bank[3]=0xFFE; fresh[3]=1.
- Mask change and disable:
  - Mask 0x03 to 0x80 mid-visit on ch0. Response: ch0 visit completes, next chan_sel=7.
  - enable=0. Response: IDLE at the next frame_done, no further res_valid.
- rd_ack collision: bank write to ch1 in the same cycle as rd_ch=1 with rd_ack=1. Response: fresh[1] stays 1; rd_data updates the following cycle.
- Reset mid-scan: assert reset_n low between frame_done pulses. Response: all outputs zero immediately; after release, the PRIME frame precedes any res_valid.
